// File: rtl/riscv_cache_hit_if.sv
// riscv_cache_hit_if: bundles the signals around the cache hit stage.
//   Request side (from tag stage) : req/wreq, adr, size, lock, prot, be, d,
//                                   pagefault, invalidate, per-way tag/valid/line
//   Core response                 : stall, ack, err, q
//   Cache memory write port       : mem_we/way/idx/tag/be/line, inv_all
//   BIU                           : stb/stb_ack, adr, size, burst, lock, prot,
//                                   we, be, d, q, d_ack, err
// master = environment (tag stage, memories, BIU); slave = riscv_cache_hit.
// size/prot use the BIU encodings: size 3'd2 = WORD, 3'd3 = DWORD.
interface riscv_cache_hit_if #(
  parameter int XLEN       = 32,
  parameter int PLEN       = XLEN,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2
);
  localparam int SETS          = (SIZE*1024)/(BLOCK_SIZE/8)/WAYS;
  localparam int BLK_OFFS_BITS = $clog2(BLOCK_SIZE/8);
  localparam int IDX_BITS      = $clog2(SETS);
  localparam int TAG_BITS      = PLEN - IDX_BITS - BLK_OFFS_BITS;

  logic                             req_i, wreq_i;
  logic [PLEN-1:0]                  adr_i;
  logic [2:0]                       size_i;
  logic                             lock_i;
  logic [2:0]                       prot_i;
  logic [XLEN/8-1:0]                be_i;
  logic [XLEN-1:0]                  d_i;
  logic                             pagefault_i, invalidate_i;
  logic [WAYS-1:0][TAG_BITS-1:0]    way_tag_i;
  logic [WAYS-1:0]                  way_valid_i;
  logic [WAYS-1:0][BLOCK_SIZE-1:0]  way_line_i;

  logic                             stall_o, ack_o, err_o;
  logic [XLEN-1:0]                  q_o;

  logic                             mem_we_o;
  logic [WAYS-1:0]                  mem_way_o;
  logic [IDX_BITS-1:0]              mem_idx_o;
  logic [TAG_BITS-1:0]              mem_tag_o;
  logic [BLOCK_SIZE/8-1:0]          mem_be_o;
  logic [BLOCK_SIZE-1:0]            mem_line_o;
  logic                             inv_all_o;

  logic                             biu_stb_o, biu_stb_ack_i;
  logic [PLEN-1:0]                  biu_adr_o;
  logic [2:0]                       biu_size_o;
  logic                             biu_burst_o, biu_lock_o;
  logic [2:0]                       biu_prot_o;
  logic                             biu_we_o;
  logic [XLEN/8-1:0]                biu_be_o;
  logic [XLEN-1:0]                  biu_d_o;
  logic [XLEN-1:0]                  biu_q_i;
  logic                             biu_d_ack_i, biu_err_i;

  modport master (
    output req_i, wreq_i, adr_i, size_i, lock_i, prot_i, be_i, d_i,
           pagefault_i, invalidate_i, way_tag_i, way_valid_i, way_line_i,
           biu_stb_ack_i, biu_q_i, biu_d_ack_i, biu_err_i,
    input  stall_o, ack_o, err_o, q_o,
           mem_we_o, mem_way_o, mem_idx_o, mem_tag_o, mem_be_o, mem_line_o, inv_all_o,
           biu_stb_o, biu_adr_o, biu_size_o, biu_burst_o, biu_lock_o, biu_prot_o,
           biu_we_o, biu_be_o, biu_d_o
  );

  modport slave (
    input  req_i, wreq_i, adr_i, size_i, lock_i, prot_i, be_i, d_i,
           pagefault_i, invalidate_i, way_tag_i, way_valid_i, way_line_i,
           biu_stb_ack_i, biu_q_i, biu_d_ack_i, biu_err_i,
    output stall_o, ack_o, err_o, q_o,
           mem_we_o, mem_way_o, mem_idx_o, mem_tag_o, mem_be_o, mem_line_o, inv_all_o,
           biu_stb_o, biu_adr_o, biu_size_o, biu_burst_o, biu_lock_o, biu_prot_o,
           biu_we_o, biu_be_o, biu_d_o
  );
endinterface

// File: rtl/riscv_cache_hit.sv
// riscv_cache_hit: cache stage following the tag lookup.
//   Read hit  -> addressed word returned the next cycle.
//   Read miss -> block fetched by a BIU burst, written to the victim way,
//                missed word returned.
//   Writes    -> write-through single BIU beat; a hit also updates the line,
//                a miss leaves the cache untouched (no write-allocate).
// Ports: rst_ni (async, active low), clk_i, bus (riscv_cache_hit_if.slave).

// Per-way compare and word select.
module riscv_cache_hit_way #(
  parameter int XLEN       = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int TAG_BITS   = 16,
  parameter int CNT_W      = 1
) (
  input  logic                  valid_i,
  input  logic [TAG_BITS-1:0]   tag_i,
  input  logic [TAG_BITS-1:0]   req_tag_i,
  input  logic [BLOCK_SIZE-1:0] line_i,
  input  logic [CNT_W-1:0]      word_i,
  output logic                  hit_o,
  output logic [XLEN-1:0]       word_o
);
  localparam int BEATS = BLOCK_SIZE/XLEN;

  logic [BEATS-1:0][XLEN-1:0] words;

  assign words  = line_i;
  assign hit_o  = valid_i & (tag_i == req_tag_i);
  assign word_o = words[word_i];
endmodule

module riscv_cache_hit #(
  parameter int XLEN       = 32,
  parameter int PLEN       = XLEN,
  parameter int SIZE       = 64,
  parameter int BLOCK_SIZE = XLEN,
  parameter int WAYS       = 2
) (
  input logic              rst_ni,
  input logic              clk_i,
  riscv_cache_hit_if.slave bus
);
  localparam int SETS          = (SIZE*1024)/(BLOCK_SIZE/8)/WAYS;
  localparam int BLK_OFFS_BITS = $clog2(BLOCK_SIZE/8);
  localparam int IDX_BITS      = $clog2(SETS);
  localparam int TAG_BITS      = PLEN - IDX_BITS - BLK_OFFS_BITS;
  localparam int BEATS         = BLOCK_SIZE/XLEN;
  localparam int BE_W          = XLEN/8;
  localparam int LBE_W         = BLOCK_SIZE/8;
  localparam int WOFF_LSB      = $clog2(XLEN/8);
  localparam int CNT_W         = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VW            = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [PLEN-1:0] BLK_MASK  = PLEN'((1 << BLK_OFFS_BITS) - 1);
  localparam logic [2:0]      FILL_SIZE = (XLEN == 64) ? 3'd3 : 3'd2;

  typedef enum logic [1:0] {ST_ARMED, ST_WRITE, ST_FILL} state_t;

  // word within the block
  function automatic logic [CNT_W-1:0] word_of(input logic [PLEN-1:0] a);
    logic [PLEN-1:0] w;
    w = (a >> WOFF_LSB) % PLEN'(BEATS);
    return w[CNT_W-1:0];
  endfunction

  state_t                      state_q, state_d;
  logic                        ack_q, ack_d, err_q, err_d;
  logic [XLEN-1:0]             q_q, q_d;
  logic                        mem_we_q, mem_we_d;
  logic [WAYS-1:0]             mem_way_q, mem_way_d;
  logic [IDX_BITS-1:0]         mem_idx_q, mem_idx_d;
  logic [TAG_BITS-1:0]         mem_tag_q, mem_tag_d;
  logic [LBE_W-1:0]            mem_be_q, mem_be_d;
  logic [BLOCK_SIZE-1:0]       mem_line_q, mem_line_d;
  logic                        inv_all_q, inv_all_d;
  logic                        biu_stb_q, biu_stb_d;
  logic                        biu_we_q, biu_we_d;
  logic                        biu_burst_q, biu_burst_d;
  logic                        biu_lock_q, biu_lock_d;
  logic [PLEN-1:0]             biu_adr_q, biu_adr_d;
  logic [2:0]                  biu_size_q, biu_size_d;
  logic [2:0]                  biu_prot_q, biu_prot_d;
  logic [BE_W-1:0]             biu_be_q, biu_be_d;
  logic [XLEN-1:0]             biu_d_q, biu_d_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            widx_q, widx_d;
  logic [IDX_BITS-1:0]         idx_q, idx_d;
  logic [TAG_BITS-1:0]         tag_q, tag_d;
  logic [VW-1:0]               rr_q, rr_d;
  logic [VW-1:0]               victim_q, victim_d;
  logic                        vic_rr_q, vic_rr_d;
  logic                        ferr_q, ferr_d;
  logic [WAYS-1:0]             hit_way_q, hit_way_d;
  logic [BEATS-1:0][XLEN-1:0]  fbuf_q, fbuf_d, fbuf_nxt;

  logic [TAG_BITS-1:0]         req_tag;
  logic [IDX_BITS-1:0]         req_idx;
  logic [CNT_W-1:0]            req_widx;
  logic [WAYS-1:0]             hit_way;
  logic                        hit_any;
  logic [WAYS-1:0][XLEN-1:0]   way_word;
  logic [XLEN-1:0]             hit_word;
  logic [VW-1:0]               vic_way;
  logic                        vic_use_rr;

  assign req_tag  = bus.adr_i[PLEN-1 -: TAG_BITS];
  assign req_idx  = bus.adr_i[BLK_OFFS_BITS +: IDX_BITS];
  assign req_widx = word_of(bus.adr_i);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    riscv_cache_hit_way #(
      .XLEN(XLEN), .BLOCK_SIZE(BLOCK_SIZE), .TAG_BITS(TAG_BITS), .CNT_W(CNT_W)
    ) u_way (
      .valid_i   (bus.way_valid_i[w]),
      .tag_i     (bus.way_tag_i[w]),
      .req_tag_i (req_tag),
      .line_i    (bus.way_line_i[w]),
      .word_i    (req_widx),
      .hit_o     (hit_way[w]),
      .word_o    (way_word[w])
    );
  end

  assign hit_any = |hit_way;

  // at most one way hits, so an OR of masked words is the mux
  always_comb begin
    hit_word = '0;
    for (int w = 0; w < WAYS; w++)
      if (hit_way[w]) hit_word |= way_word[w];
  end

  // lowest invalid way wins; all valid falls back to round robin
  always_comb begin
    vic_way    = '0;
    vic_use_rr = 1'b1;
    for (int w = WAYS-1; w >= 0; w--)
      if (!bus.way_valid_i[w]) begin
        vic_way    = VW'(w);
        vic_use_rr = 1'b0;
      end
    if (vic_use_rr) vic_way = rr_q;
  end

  always_comb begin
    state_d     = state_q;
    ack_d       = 1'b0;
    err_d       = 1'b0;
    q_d         = '0;
    mem_we_d    = 1'b0;
    mem_way_d   = '0;
    mem_be_d    = '0;
    mem_idx_d   = mem_idx_q;
    mem_tag_d   = mem_tag_q;
    mem_line_d  = mem_line_q;
    inv_all_d   = 1'b0;
    biu_stb_d   = biu_stb_q;
    biu_we_d    = biu_we_q;
    biu_burst_d = biu_burst_q;
    biu_lock_d  = biu_lock_q;
    biu_adr_d   = biu_adr_q;
    biu_size_d  = biu_size_q;
    biu_prot_d  = biu_prot_q;
    biu_be_d    = biu_be_q;
    biu_d_d     = biu_d_q;
    cnt_d       = cnt_q;
    widx_d      = widx_q;
    idx_d       = idx_q;
    tag_d       = tag_q;
    rr_d        = rr_q;
    victim_d    = victim_q;
    vic_rr_d    = vic_rr_q;
    ferr_d      = ferr_q;
    hit_way_d   = hit_way_q;
    fbuf_d      = fbuf_q;
    fbuf_nxt    = fbuf_q;
    fbuf_nxt[cnt_q] = bus.biu_q_i;

    // the strobe drops once the BIU has taken the request
    if (biu_stb_q && bus.biu_stb_ack_i) biu_stb_d = 1'b0;

    unique case (state_q)
      ST_ARMED: begin
        if (bus.req_i && bus.pagefault_i) begin
          ack_d = 1'b1;
          err_d = 1'b1;
        end else if (bus.invalidate_i) begin
          inv_all_d = 1'b1;
          ack_d     = 1'b1;
        end else if (bus.req_i && !bus.wreq_i && hit_any) begin
          ack_d = 1'b1;
          q_d   = hit_word;
        end else if (bus.req_i) begin
          widx_d     = req_widx;
          idx_d      = req_idx;
          tag_d      = req_tag;
          biu_stb_d  = 1'b1;
          biu_lock_d = bus.lock_i;
          biu_prot_d = bus.prot_i;
          biu_d_d    = bus.d_i;
          if (bus.wreq_i) begin
            state_d     = ST_WRITE;
            biu_we_d    = 1'b1;
            biu_burst_d = 1'b0;
            biu_adr_d   = bus.adr_i;
            biu_size_d  = bus.size_i;
            biu_be_d    = bus.be_i;
            hit_way_d   = hit_way;
          end else begin
            state_d     = ST_FILL;
            biu_we_d    = 1'b0;
            biu_burst_d = 1'b1;
            biu_adr_d   = bus.adr_i & ~BLK_MASK;
            biu_size_d  = FILL_SIZE;
            biu_be_d    = '1;
            cnt_d       = '0;
            ferr_d      = 1'b0;
            victim_d    = vic_way;
            vic_rr_d    = vic_use_rr;
          end
        end
      end

      ST_WRITE: begin
        if (bus.biu_d_ack_i) begin
          state_d  = ST_ARMED;
          biu_we_d = 1'b0;
          ack_d    = 1'b1;
          err_d    = bus.biu_err_i;
          if (|hit_way_q && !bus.biu_err_i) begin
            mem_we_d   = 1'b1;
            mem_way_d  = hit_way_q;
            mem_be_d   = LBE_W'(biu_be_q) << (int'(widx_q) * BE_W);
            mem_line_d = {BEATS{biu_d_q}};
            mem_idx_d  = idx_q;
            mem_tag_d  = tag_q;
          end
        end
      end

      ST_FILL: begin
        if (bus.biu_d_ack_i) begin
          fbuf_d = fbuf_nxt;
          ferr_d = ferr_q | bus.biu_err_i;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS-1)) begin
            state_d     = ST_ARMED;
            cnt_d       = '0;
            biu_burst_d = 1'b0;
            ack_d       = 1'b1;
            if (ferr_q || bus.biu_err_i) begin
              err_d = 1'b1;
            end else begin
              mem_we_d   = 1'b1;
              mem_way_d  = WAYS'(1) << victim_q;
              mem_be_d   = '1;
              mem_line_d = fbuf_nxt;
              mem_idx_d  = idx_q;
              mem_tag_d  = tag_q;
              q_d        = fbuf_nxt[widx_q];
              if (vic_rr_q) rr_d = (rr_q == VW'(WAYS-1)) ? '0 : rr_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_ARMED;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ARMED;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      q_q         <= '0;
      mem_we_q    <= 1'b0;
      mem_way_q   <= '0;
      mem_idx_q   <= '0;
      mem_tag_q   <= '0;
      mem_be_q    <= '0;
      mem_line_q  <= '0;
      inv_all_q   <= 1'b0;
      biu_stb_q   <= 1'b0;
      biu_we_q    <= 1'b0;
      biu_burst_q <= 1'b0;
      biu_lock_q  <= 1'b0;
      biu_adr_q   <= '0;
      biu_size_q  <= '0;
      biu_prot_q  <= '0;
      biu_be_q    <= '0;
      biu_d_q     <= '0;
      cnt_q       <= '0;
      widx_q      <= '0;
      idx_q       <= '0;
      tag_q       <= '0;
      rr_q        <= '0;
      victim_q    <= '0;
      vic_rr_q    <= 1'b0;
      ferr_q      <= 1'b0;
      hit_way_q   <= '0;
      fbuf_q      <= '0;
    end else begin
      state_q     <= state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      q_q         <= q_d;
      mem_we_q    <= mem_we_d;
      mem_way_q   <= mem_way_d;
      mem_idx_q   <= mem_idx_d;
      mem_tag_q   <= mem_tag_d;
      mem_be_q    <= mem_be_d;
      mem_line_q  <= mem_line_d;
      inv_all_q   <= inv_all_d;
      biu_stb_q   <= biu_stb_d;
      biu_we_q    <= biu_we_d;
      biu_burst_q <= biu_burst_d;
      biu_lock_q  <= biu_lock_d;
      biu_adr_q   <= biu_adr_d;
      biu_size_q  <= biu_size_d;
      biu_prot_q  <= biu_prot_d;
      biu_be_q    <= biu_be_d;
      biu_d_q     <= biu_d_d;
      cnt_q       <= cnt_d;
      widx_q      <= widx_d;
      idx_q       <= idx_d;
      tag_q       <= tag_d;
      rr_q        <= rr_d;
      victim_q    <= victim_d;
      vic_rr_q    <= vic_rr_d;
      ferr_q      <= ferr_d;
      hit_way_q   <= hit_way_d;
      fbuf_q      <= fbuf_d;
    end
  end

  assign bus.stall_o     = (state_q != ST_ARMED) |
                           (bus.req_i & ~bus.pagefault_i & (bus.wreq_i | ~hit_any));
  assign bus.ack_o       = ack_q;
  assign bus.err_o       = err_q;
  assign bus.q_o         = q_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_way_o   = mem_way_q;
  assign bus.mem_idx_o   = mem_idx_q;
  assign bus.mem_tag_o   = mem_tag_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_line_o  = mem_line_q;
  assign bus.inv_all_o   = inv_all_q;
  assign bus.biu_stb_o   = biu_stb_q;
  assign bus.biu_adr_o   = biu_adr_q;
  assign bus.biu_size_o  = biu_size_q;
  assign bus.biu_burst_o = biu_burst_q;
  assign bus.biu_lock_o  = biu_lock_q;
  assign bus.biu_prot_o  = biu_prot_q;
  assign bus.biu_we_o    = biu_we_q;
  assign bus.biu_be_o    = biu_be_q;
  assign bus.biu_d_o     = biu_d_q;

  // a tag may live in only one way of a set
  a_onehot_hit: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (bus.req_i && !bus.pagefault_i) |-> $onehot0(hit_way))
    else $error("multiple ways hit");
endmodule

// File: tb/tb_riscv_cache_hit.sv
module tb_riscv_cache_hit;
  localparam int XLEN = 32, PLEN = 32, SIZE = 64, BLOCK_SIZE = 128, WAYS = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  riscv_cache_hit_if #(.XLEN(XLEN), .PLEN(PLEN), .SIZE(SIZE), .BLOCK_SIZE(BLOCK_SIZE), .WAYS(WAYS)) bus ();

  riscv_cache_hit #(.XLEN(XLEN), .PLEN(PLEN), .SIZE(SIZE), .BLOCK_SIZE(BLOCK_SIZE), .WAYS(WAYS)) dut (
    .rst_ni (rst_n),
    .clk_i  (clk),
    .bus    (bus)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic biu_idle();
    bus.biu_stb_ack_i = 1'b0;
    bus.biu_d_ack_i   = 1'b0;
    bus.biu_err_i     = 1'b0;
    bus.biu_q_i       = '0;
  endtask

  // read miss + 4-beat fill; beat b returns base+b, error injected on err_beat
  task automatic do_fill(input string nm, input logic [31:0] a, input logic [31:0] base,
                         input int err_beat, input logic [1:0] exp_way);
    logic [127:0] line;
    logic [31:0]  wrd;
    line = {base + 32'd3, base + 32'd2, base + 32'd1, base};
    wrd  = base + 32'(a[3:2]);
    bus.req_i = 1'b1; bus.wreq_i = 1'b0; bus.adr_i = a;
    #1 chk({nm, "_stall_miss"}, bus.stall_o, 1);
    tick();
    bus.req_i = 1'b0;
    chk({nm, "_stb"},   bus.biu_stb_o, 1);
    chk({nm, "_adr"},   bus.biu_adr_o, a & ~32'hF);
    chk({nm, "_burst"}, bus.biu_burst_o, 1);
    chk({nm, "_we"},    bus.biu_we_o, 0);
    chk({nm, "_size"},  bus.biu_size_o, 3'd2);
    for (int b = 0; b < 4; b++) begin
      bus.biu_stb_ack_i = (b == 0);
      bus.biu_d_ack_i   = 1'b1;
      bus.biu_q_i       = base + 32'(b);
      bus.biu_err_i     = (b == err_beat);
      tick();
      if (b < 3) begin
        chk({nm, "_stall_fill"}, bus.stall_o, 1);
        chk({nm, "_memwe_fill"}, bus.mem_we_o, 0);
        chk({nm, "_ack_fill"},   bus.ack_o, 0);
      end
      if (b == 0) chk({nm, "_stb_drop"}, bus.biu_stb_o, 0);
    end
    biu_idle();
    chk({nm, "_ack"}, bus.ack_o, 1);
    if (err_beat >= 0) begin
      chk({nm, "_err"},   bus.err_o, 1);
      chk({nm, "_memwe"}, bus.mem_we_o, 0);
    end else begin
      chk({nm, "_err"},   bus.err_o, 0);
      chk({nm, "_memwe"}, bus.mem_we_o, 1);
      chk({nm, "_way"},   bus.mem_way_o, exp_way);
      chk({nm, "_be"},    bus.mem_be_o, 16'hFFFF);
      chk({nm, "_line"},  bus.mem_line_o, line);
      chk({nm, "_idx"},   bus.mem_idx_o, a[14:4]);
      chk({nm, "_tag"},   bus.mem_tag_o, a[31:15]);
      chk({nm, "_q"},     bus.q_o, wrd);
    end
    chk({nm, "_stall_done"}, bus.stall_o, 0);
    tick();
    chk({nm, "_ack_pulse"},   bus.ack_o, 0);
    chk({nm, "_memwe_pulse"}, bus.mem_we_o, 0);
  endtask

  initial begin
    bus.req_i = 0; bus.wreq_i = 0; bus.adr_i = '0; bus.size_i = 3'd2;
    bus.lock_i = 0; bus.prot_i = '0; bus.be_i = 4'hF; bus.d_i = '0;
    bus.pagefault_i = 0; bus.invalidate_i = 0;
    bus.way_tag_i[0] = 17'd5; bus.way_tag_i[1] = 17'd1;
    bus.way_valid_i = 2'b10;
    bus.way_line_i[0] = '0;
    bus.way_line_i[1] = {32'h1313_0003, 32'h1212_0002, 32'h1111_0001, 32'h1010_0000};
    biu_idle();

    // reset
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ack",   bus.ack_o, 0);
    chk("rst_err",   bus.err_o, 0);
    chk("rst_q",     bus.q_o, 0);
    chk("rst_memwe", bus.mem_we_o, 0);
    chk("rst_way",   bus.mem_way_o, 0);
    chk("rst_stb",   bus.biu_stb_o, 0);
    chk("rst_inv",   bus.inv_all_o, 0);
    chk("rst_stall", bus.stall_o, 0);

    // back-to-back read hits in way 1
    bus.req_i = 1'b1; bus.adr_i = 32'h0000_8008;
    #1 chk("hit_stall", bus.stall_o, 0);
    tick();
    chk("hit_ack", bus.ack_o, 1);
    chk("hit_q",   bus.q_o, 32'h1212_0002);
    bus.adr_i = 32'h0000_8004;
    #1 chk("hit2_stall", bus.stall_o, 0);
    tick();
    chk("hit2_ack", bus.ack_o, 1);
    chk("hit2_q",   bus.q_o, 32'h1111_0001);
    bus.req_i = 1'b0;
    tick();
    chk("hit_ack_pulse", bus.ack_o, 0);
    chk("hit_q_pulse",   bus.q_o, 0);
    chk("hit_no_stb",    bus.biu_stb_o, 0);

    // read miss, way 0 invalid -> victim way 0
    do_fill("miss", 32'h0000_1234, 32'hA0, -1, 2'b01);

    // write hit: be 0011 at word 2
    bus.req_i = 1'b1; bus.wreq_i = 1'b1; bus.adr_i = 32'h0000_8008;
    bus.be_i = 4'b0011; bus.d_i = 32'h5555;
    #1 chk("wh_stall", bus.stall_o, 1);
    tick();
    bus.req_i = 1'b0; bus.wreq_i = 1'b0;
    chk("wh_stb",   bus.biu_stb_o, 1);
    chk("wh_we",    bus.biu_we_o, 1);
    chk("wh_adr",   bus.biu_adr_o, 32'h0000_8008);
    chk("wh_be",    bus.biu_be_o, 4'b0011);
    chk("wh_d",     bus.biu_d_o, 32'h5555);
    chk("wh_burst", bus.biu_burst_o, 0);
    bus.biu_stb_ack_i = 1'b1; bus.biu_d_ack_i = 1'b1;
    tick();
    biu_idle();
    chk("wh_ack",    bus.ack_o, 1);
    chk("wh_err",    bus.err_o, 0);
    chk("wh_memwe",  bus.mem_we_o, 1);
    chk("wh_memway", bus.mem_way_o, 2'b10);
    chk("wh_membe",  bus.mem_be_o, 16'h0300);
    chk("wh_line",   bus.mem_line_o, {4{32'h0000_5555}});
    chk("wh_stbdn",  bus.biu_stb_o, 0);
    tick();
    chk("wh_memwe_pulse", bus.mem_we_o, 0);

    // write miss: stb accepted, then data ack a cycle later
    bus.req_i = 1'b1; bus.wreq_i = 1'b1; bus.adr_i = 32'h0001_0004;
    bus.be_i = 4'hF; bus.d_i = 32'hDEAD_BEEF;
    tick();
    bus.req_i = 1'b0; bus.wreq_i = 1'b0;
    chk("wm_stb", bus.biu_stb_o, 1);
    bus.biu_stb_ack_i = 1'b1;
    tick();
    bus.biu_stb_ack_i = 1'b0;
    chk("wm_stb_drop", bus.biu_stb_o, 0);
    chk("wm_wait_ack", bus.ack_o, 0);
    chk("wm_stall",    bus.stall_o, 1);
    bus.biu_d_ack_i = 1'b1;
    tick();
    biu_idle();
    chk("wm_ack",   bus.ack_o, 1);
    chk("wm_memwe", bus.mem_we_o, 0);

    // bus error on beat 2 of a fill
    bus.way_valid_i = 2'b00;
    do_fill("ferr", 32'h0000_2000, 32'hB0, 2, 2'b01);

    // page fault on a read
    bus.way_valid_i = 2'b10;
    bus.req_i = 1'b1; bus.adr_i = 32'h0000_1234; bus.pagefault_i = 1'b1;
    #1 chk("pf_stall", bus.stall_o, 0);
    tick();
    bus.req_i = 1'b0; bus.pagefault_i = 1'b0;
    chk("pf_ack", bus.ack_o, 1);
    chk("pf_err", bus.err_o, 1);
    chk("pf_stb", bus.biu_stb_o, 0);

    // invalidate all
    bus.invalidate_i = 1'b1;
    tick();
    bus.invalidate_i = 1'b0;
    chk("inv_pulse", bus.inv_all_o, 1);
    chk("inv_ack",   bus.ack_o, 1);
    tick();
    chk("inv_drop",  bus.inv_all_o, 0);

    // round robin with both ways valid
    bus.way_valid_i = 2'b11; bus.way_tag_i[0] = 17'd5; bus.way_tag_i[1] = 17'd6;
    do_fill("rr0", 32'h0000_3000, 32'hD0, -1, 2'b01);
    do_fill("rr1", 32'h0000_3010, 32'hD4, -1, 2'b10);
    do_fill("rr2", 32'h0000_3020, 32'hD8, -1, 2'b01);

    // reset during beat 1 of a fill
    bus.req_i = 1'b1; bus.adr_i = 32'h0000_4000;
    tick();
    bus.req_i = 1'b0;
    bus.biu_stb_ack_i = 1'b1; bus.biu_d_ack_i = 1'b1; bus.biu_q_i = 32'hC0;
    tick();
    bus.biu_stb_ack_i = 1'b0; bus.biu_q_i = 32'hC1;
    rst_n = 1'b0;
    #1;
    chk("mrst_ack",   bus.ack_o, 0);
    chk("mrst_err",   bus.err_o, 0);
    chk("mrst_q",     bus.q_o, 0);
    chk("mrst_memwe", bus.mem_we_o, 0);
    chk("mrst_way",   bus.mem_way_o, 0);
    chk("mrst_be",    bus.mem_be_o, 0);
    chk("mrst_stb",   bus.biu_stb_o, 0);
    chk("mrst_we",    bus.biu_we_o, 0);
    chk("mrst_burst", bus.biu_burst_o, 0);
    chk("mrst_stall", bus.stall_o, 0);
    biu_idle();
    tick();
    chk("mrst_memwe_hold", bus.mem_we_o, 0);
    rst_n = 1'b1;
    tick();
    // pointer back at 0 after reset
    do_fill("post_rst", 32'h0000_4000, 32'hC0, -1, 2'b01);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/riscv_cache_hit.md
Name: riscv_cache_hit

Overview:
- Pipeline stage directly downstream of the cache tag stage.
- Consumes the registered request plus the per-way tag, valid and line read data.
- On a read hit, returns the addressed word to the core.
- On a read miss, fetches the whole block over the BIU, writes it into the cache memories and returns the missed word.
- Writes are write-through with no write-allocate.

Parameters:
- XLEN, 32, data width.
- PLEN, XLEN, physical address width.
- SIZE, 64, cache size in KBytes; same meaning as the tag stage.
- BLOCK_SIZE, XLEN, block size in bits; must be a multiple of XLEN.
- WAYS, 2, associativity (1..8).
- Derived localparams, same as the tag stage: SETS, BLK_OFFS_BITS, IDX_BITS, TAG_BITS.
- Derived localparam BEATS = BLOCK_SIZE/XLEN.

Ports:
- rst_ni  in  1  asynchronous active-low reset
- clk_i  in  1  single clock
- req_i, wreq_i  in  1  request / write request from the tag stage
- adr_i  in  PLEN  physical address
- size_i  in  biu_size_t  transfer size
- lock_i  in  1  locked access
- prot_i  in  biu_prot_t  protection
- be_i  in  XLEN/8  byte enables
- d_i  in  XLEN  write data
- pagefault_i, invalidate_i  in  1  from the tag stage
- way_tag_i  in  WAYS*TAG_BITS  tags read for adr_i's index
- way_valid_i  in  WAYS  valid bits
- way_line_i  in  WAYS*BLOCK_SIZE  line data
- stall_o  out  1  stall upstream stages
- ack_o  out  1  request complete
- err_o  out  1  request completed with error
- q_o  out  XLEN  read data
- mem_we_o  out  1  write line/tag memories
- mem_way_o  out  WAYS  one-hot way select
- mem_idx_o  out  IDX_BITS  set index
- mem_tag_o  out  TAG_BITS  tag to write
- mem_be_o  out  BLOCK_SIZE/8  line byte enables
- mem_line_o  out  BLOCK_SIZE  line data to write
- inv_all_o  out  1  clear all valid bits
- biu_stb_o  out  1  BIU request strobe
- biu_stb_ack_i  in  1  request accepted
- biu_adr_o  out  PLEN  BIU address
- biu_size_o  out  biu_size_t  BIU size
- biu_burst_o  out  1  BEATS-beat incrementing burst
- biu_lock_o  out  1  BIU lock
- biu_prot_o  out  biu_prot_t  BIU protection
- biu_we_o  out  1  BIU write
- biu_be_o  out  XLEN/8  BIU byte enables
- biu_d_o  out  XLEN  BIU write data
- biu_q_i  in  XLEN  BIU read data
- biu_d_ack_i  in  1  data beat acknowledge
- biu_err_i  in  1  bus error

Behaviour:
- Reset: state=ARMED; all of the following are 0:
  - ack_o, err_o, q_o
  - mem_we_o, mem_way_o, mem_be_o
  - inv_all_o
  - biu_stb_o, biu_we_o, biu_burst_o
  - beat counter
  - victim pointer
- Reset mid-operation aborts immediately: no line is written, and the outstanding BIU transaction is dropped (the BIU is reset by the same rst_ni).
- Hit is computed combinationally: hit_way[w] = way_valid_i[w] & (way_tag_i[w] == adr_i[PLEN-1 -: TAG_BITS]). More than one hit way is illegal; assert in simulation.
- stall_o is combinational: (state != ARMED) | (req_i & ~pagefault_i & (wreq_i | ~hit)).
- ack_o, err_o and q_o are registered and pulse for exactly one cycle.
- ARMED:
  - pagefault_i & req_i: next cycle ack_o=1, err_o=1; no BIU or memory access.
  - invalidate_i: inv_all_o pulses for 1 cycle; ack next cycle.
  - Read hit: next cycle ack_o=1, q_o = word of the hit line at adr_i[BLK_OFFS_BITS-1:log2(XLEN/8)]. Back-to-back hits ack every cycle.
  - Read miss: latch request → FILL.
  - Write hit and write miss both → WRITE.
- WRITE:
  - biu_stb_o held with the single-beat request (adr, size, be, d, lock, prot; biu_we_o=1) until biu_stb_ack_i.
  - Wait for biu_d_ack_i, then ack_o next cycle → ARMED; err_o = biu_err_i.
  - On a write hit without error, mem_we_o pulses with the hit way, the be_i byte-lane mask shifted to the word offset, and d_i replicated. A write miss leaves the cache memories unchanged.
- FILL:
  - biu_stb_o held with biu_adr_o = adr block-aligned, biu_burst_o=1, size=WORD (DWORD if XLEN=64), until biu_stb_ack_i.
  - Each biu_d_ack_i stores biu_q_i into the fill buffer at the beat count and increments the count.
  - After beat BEATS-1:
    - mem_we_o=1 for 1 cycle with all mem_be_o set, mem_tag_o, mem_idx_o and the victim way.
    - ack_o=1 with q_o taken from the fill buffer word at the offset.
    - → ARMED.
  - biu_err_i on any beat: remaining beats are still counted; no memory write; ack_o=1 with err_o=1 → ARMED.
- Victim selection: the lowest-index invalid way. If all ways are valid, the round-robin pointer is used; the pointer increments modulo WAYS on every fill that used it.
- A simultaneous biu_stb_ack_i and biu_d_ack_i in the same cycle is legal and counts as one beat.

Test Plan:
- Reset, then a read hit (WAYS=2, way1 valid, tag match, word offset 2) → ack_o=1 one cycle later with q_o = line word 2; stall_o=0 throughout.
- Read miss with BLOCK_SIZE=128, XLEN=32, adr 0x1234 → biu_adr_o=0x1230, burst of 4 beats 0xA0..0xA3 → mem_we_o one cycle with the full line; ack_o with q_o=0xA1; stall_o high for the whole fill.
- Write hit with be_i=4'b0011, d_i=0x5555 → single BIU write; mem_be_o covers only those lanes at the word offset; ack_o after biu_d_ack_i.
- Write miss → BIU write issued; mem_we_o stays 0.
- biu_err_i on beat 2 of a fill → no mem_we_o; ack_o=1, err_o=1.
- pagefault_i on a read → ack_o=1, err_o=1 next cycle, no biu_stb_o.
- Victim selection with both ways valid over three consecutive misses → victim ways 0, 1, 0.
- rst_ni low during beat 1 of a fill → all outputs 0 and state ARMED; the next request is serviced normally.
